// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and constants for the data RAM arbiter.
// Holds the arbiter FSM encoding, the debug byte-lane mask and the saturating-increment helper.
package data_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_e;

  localparam logic [3:0] DBG_SEL_FULL = 4'b1111;
  localparam logic [7:0] SAT8_MAX     = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == SAT8_MAX) ? SAT8_MAX : val + 8'd1;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_counter.sv
// Free-running event counter that wraps at 2^WIDTH.
// Counts one per enabled cycle, no flow control.
module Counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/data_ram_arbiter_sat_counter8.sv
// 8-bit counter that sticks at 255; clear has priority over enable.
// Single-cycle update, no flow control.
module sat_counter8
  import data_ram_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [7:0] o_cnt
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en) begin
      r_cnt <= sat_inc8(r_cnt);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the data RAM between the MEM stage (absolute priority, never stalled) and a debug port.
// Debug access completes 2 cycles after acceptance plus one cycle per CPU-busy cycle.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS    = 12,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cpu_en,
  input  logic                 i_cpu_rw,
  input  logic [ADDR_BITS-3:0] i_cpu_addr,
  input  logic [3:0]           i_cpu_sel,
  input  logic [31:0]          i_cpu_wdata,
  output logic [31:0]          o_cpu_rdata,
  input  logic                 i_dbg_req,
  input  logic                 i_dbg_rw,
  input  logic [ADDR_BITS-3:0] i_dbg_addr,
  input  logic [31:0]          i_dbg_wdata,
  output logic                 o_dbg_ack,
  output logic [31:0]          o_dbg_rdata,
  output logic                 o_dbg_starved,
  output logic [31:0]          o_conflict_cnt,
  output logic [ADDR_BITS-3:0] o_ram_addr,
  output logic [3:0]           o_ram_sel,
  output logic                 o_ram_rw,
  output logic [31:0]          o_ram_data_in,
  input  logic [31:0]          i_ram_data_out
);

  localparam logic [7:0] LP_STARVE = 8'(STARVE_LIMIT);

  arb_state_e           r_state;
  arb_state_e           w_next_state;
  logic                 w_accept;
  logic                 w_grant;
  logic                 w_cpu_wins;
  logic [7:0]           w_wait_cnt;

  logic                 r_req_rw;
  logic [ADDR_BITS-3:0] r_req_addr;
  logic [31:0]          r_req_wdata;
  logic [31:0]          r_dbg_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The grant decision looks only at this cycle's cpu_en; no lookahead.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_grant      = 1'b0;
    w_cpu_wins   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_dbg_req) begin
          w_accept     = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_cpu_en) begin
          w_cpu_wins = 1'b1;
        end else begin
          w_grant      = 1'b1;
          w_next_state = ST_ACK;
        end
      end
      ST_ACK: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_rw    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= 32'd0;
    end else if (w_accept) begin
      r_req_rw    <= i_dbg_rw;
      r_req_addr  <= i_dbg_addr;
      r_req_wdata <= i_dbg_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dbg_rdata <= 32'd0;
    end else if (w_grant && !r_req_rw) begin
      r_dbg_rdata <= i_ram_data_out;
    end
  end

  // Debug side drives the RAM only from its request registers, never from dbg_* inputs.
  always_comb begin
    o_ram_addr    = i_cpu_addr;
    o_ram_sel     = i_cpu_sel;
    o_ram_rw      = i_cpu_en & i_cpu_rw;
    o_ram_data_in = i_cpu_wdata;
    if (w_grant) begin
      o_ram_addr    = r_req_addr;
      o_ram_sel     = DBG_SEL_FULL;
      o_ram_rw      = r_req_rw;
      o_ram_data_in = r_req_wdata;
    end
  end

  sat_counter8 u_wait_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_accept),
    .i_en    (w_cpu_wins),
    .o_cnt   (w_wait_cnt)
  );

  Counter #(
    .WIDTH (32)
  ) u_conflict_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_cpu_wins),
    .o_count (o_conflict_cnt)
  );

  assign o_cpu_rdata   = i_ram_data_out;
  assign o_dbg_ack     = (r_state == ST_ACK);
  assign o_dbg_rdata   = r_dbg_rdata;
  assign o_dbg_starved = (r_state == ST_WAIT) && (w_wait_cnt >= LP_STARVE);

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Shares the single-port, asynchronous-read data RAM between the pipeline's MEM stage and a debug/display port. The CPU has absolute priority and is never stalled. The debug port is served only in cycles where the MEM stage makes no RAM access, through a req/ack handshake. The block sits between the CPU's `ram_*` outputs and the data RAM, and also reports contention statistics for the board display.

## Interface
Parameters:
- `ADDR_BITS`, 12: byte-address width; word address is `ADDR_BITS-2` bits.
- `STARVE_LIMIT`, 16: wait cycles after which `dbg_starved` asserts; must be ≥1 and ≤255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_en` in 1: MEM stage accesses RAM this cycle (load or store).
- `cpu_rw` in 1: 1 = store.
- `cpu_addr` in `ADDR_BITS-2`: CPU word address.
- `cpu_sel` in 4: CPU byte lanes.
- `cpu_wdata` in 32: CPU store data.
- `cpu_rdata` out 32: RAM read data, combinational pass-through.
- `dbg_req` in 1: debug request; sampled only in IDLE.
- `dbg_rw` in 1: 1 = write.
- `dbg_addr` in `ADDR_BITS-2`: debug word address.
- `dbg_wdata` in 32: debug write data; always full word.
- `dbg_ack` out 1: one-cycle completion pulse.
- `dbg_rdata` out 32: registered read data, held until the next debug read completes.
- `dbg_starved` out 1: the pending request has waited ≥ `STARVE_LIMIT` cycles.
- `conflict_cnt` out 32: total cycles in which a pending debug request lost to the CPU.
- `ram_addr` out `ADDR_BITS-2`, `ram_sel` out 4, `ram_rw` out 1, `ram_data_in` out 32: RAM drive.
- `ram_data_out` in 32: RAM asynchronous read data.

## Operation
FSM states and transitions:
- IDLE: if `dbg_req` = 1, latch `dbg_rw`, `dbg_addr` and `dbg_wdata` into request registers and clear `wait_cnt`; go to WAIT.
- WAIT, `cpu_en` = 1: the CPU owns the RAM. Increment `wait_cnt`, saturating at 255. Increment `conflict_cnt`, wrapping at 2^32. Stay in WAIT.
- WAIT, `cpu_en` = 0: grant the debug port. The RAM is driven from the request registers with `ram_sel` = 4'b1111. On a read, capture `ram_data_out` into `dbg_rdata` at the clock edge. Go to ACK.
- ACK: `dbg_ack` = 1 for this cycle only; go to IDLE. `dbg_req` is ignored in ACK. A requester that holds `dbg_req` high is re-accepted in the following IDLE cycle.

RAM mux (combinational):
- Outside a debug grant, the RAM is driven from `cpu_*`.
- When `cpu_en` = 0 and there is no grant, `ram_rw` = 0.
- `cpu_rdata` = `ram_data_out` at all times.

Starvation flag:
- `dbg_starved` = (state == WAIT) && (`wait_cnt` ≥ `STARVE_LIMIT`).
- It is informational only; the CPU is never stalled.

Debug write with `cpu_en` = 1: the write is deferred until an idle cycle. The CPU store in that cycle proceeds normally.

## Timing
- Reset values: state IDLE, `dbg_ack` 0, `dbg_rdata` 0, `dbg_starved` 0, `conflict_cnt` 0, `wait_cnt` 0, request registers 0.
- Minimum latency is 2 cycles from the edge that samples `dbg_req` to the edge that ends the `dbg_ack` cycle: IDLE→WAIT, WAIT(grant)→ACK.
- Each CPU-busy cycle adds exactly 1 cycle of latency and 1 count to `conflict_cnt`.
- `dbg_rdata` updates at the edge leaving the grant cycle and is valid while `dbg_ack` = 1.
- `cpu_en` toggling within WAIT: the decision uses only the current-cycle value; there is no lookahead.
- Reset asserted mid-request (any state): the request is dropped, no ack is issued, and all registers clear immediately (asynchronous).
- There are no combinational paths from `dbg_*` inputs to `ram_*`; the debug path is fully registered.

## Structure
- Shared package holds the FSM state enum (IDLE/WAIT/ACK, 2 bits) and the constant `DBG_SEL_FULL` = 4'b1111.
- One sub-module, `sat_counter8`: 8-bit saturating counter with clear and enable, used for `wait_cnt`.
- `conflict_cnt` reuses the team's existing `Counter` block, gated by (state == WAIT && `cpu_en`).
- Everything else lives in one module.

## Test plan
- Reset, then `dbg_req` read of addr 0x10 holding 0xDEADBEEF with `cpu_en` = 0 → `dbg_ack` 2 cycles after req is sampled, `dbg_rdata` = 0xDEADBEEF, `conflict_cnt` = 0.
- Debug read while `cpu_en` = 1 for 5 cycles, then 0 → ack at cycle 7, `conflict_cnt` = 5, `cpu_rdata` correct for each CPU load.
- Debug write of 0x12345678 to addr 3 concurrent with a CPU store to addr 3 for 2 cycles → CPU store lands first, the debug write lands on the first idle cycle, and the final RAM word is 0x12345678.
- `cpu_en` held at 1 for 20 cycles with `STARVE_LIMIT` = 16 → `dbg_starved` rises at wait cycle 16, stays high, and clears when the state leaves WAIT.
- Reset asserted in WAIT → no ack, all outputs 0 immediately; a new request after release completes normally.
- Back-to-back: `dbg_req` held high for 3 requests with CPU idle → 3 acks spaced 3 cycles apart, with `dbg_rdata` matching each address.
